imply_queue: RTL and testbench

IMPLY_QUEUE -- requirements
Module: imply_queue

---
 rtl/imply_queue.sv | 136 +++++++++++++
 tb/tb_imply_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/imply_queue.sv
// Implied-literal FIFO between BCP core and control, with head show-ahead.
// Optional per-variable dedup/conflict tracking enabled by IMPLY_QUEUE_DEDUP_EN.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module imply_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [`MAX_VARS_BITS-1:0]  var_in,
  input  logic                       val_in,
  input  logic                       type_in,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       empty_imply,
  output logic                       full_imply,
  output logic [`MAX_VARS_BITS-1:0]  var_out_imply,
  output logic                       val_out_imply,
  output logic                       type_out_imply,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       conflict_imply,
  output logic                       dup_drop,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned VW = `MAX_VARS_BITS;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [VW+1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_live_push;
  logic            w_reject;
  logic            w_pop_ok;
  logic            w_push_ok;
  logic            w_ovf;
  logic [VW+1:0]   w_head_entry;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_FULL);
  assign w_live_push  = push & ~flush;
  assign w_head_entry = r_mem[r_head];

  assign w_pop_ok  = pop & ~w_empty & ~flush;
  assign w_push_ok = w_live_push & ~w_reject & (~w_full | pop);
  assign w_ovf     = w_live_push & ~w_reject & w_full & ~pop;

`ifdef IMPLY_QUEUE_DEDUP_EN
  logic [2**VW-1:0] r_pend;
  logic [2**VW-1:0] r_pval;
  logic             r_conflict;
  logic             w_hit;
  logic             w_dup;
  logic             w_conf;

  // Lookup uses pre-pop state, so an entry leaving this cycle still blocks a push.
  assign w_hit    = r_pend[var_in];
  assign w_dup    = w_live_push & w_hit & (r_pval[var_in] == val_in);
  assign w_conf   = w_live_push & w_hit & (r_pval[var_in] != val_in);
  assign w_reject = w_dup | w_conf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_pval     <= '0;
      r_conflict <= 1'b0;
    end else if (flush) begin
      r_pend     <= '0;
      r_pval     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_pop_ok)
        r_pend[w_head_entry[VW-1:0]] <= 1'b0;
      if (w_push_ok) begin
        r_pend[var_in] <= 1'b1;
        r_pval[var_in] <= val_in;
      end
      if (w_conf)
        r_conflict <= 1'b1;
    end
  end

  assign conflict_imply = r_conflict;
  assign dup_drop       = w_dup;
`else
  assign w_reject       = 1'b0;
  assign conflict_imply = 1'b0;
  assign dup_drop       = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop_ok)
        r_head <= r_head + PW'(1);
      if (w_push_ok)
        r_tail <= r_tail + PW'(1);
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
      if (w_ovf)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_push_ok)
      r_mem[r_tail] <= {type_in, val_in, var_in};
  end

  // Storage is not reset; gating on empty keeps head outputs at 0 during reset.
  assign empty_imply    = w_empty;
  assign full_imply     = w_full;
  assign count          = r_count;
  assign overflow       = r_overflow;
  assign var_out_imply  = w_empty ? '0   : w_head_entry[VW-1:0];
  assign val_out_imply  = w_empty ? 1'b0 : w_head_entry[VW];
  assign type_out_imply = w_empty ? 1'b0 : w_head_entry[VW+1];

endmodule

// File: tb/tb_imply_queue.sv
// Directed, table-driven checks of imply_queue (DEPTH=16); dedup expectations
// follow whether IMPLY_QUEUE_DEDUP_EN is defined for the build.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module tb_imply_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned VW    = `MAX_VARS_BITS;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push  = 1'b0;
  logic [VW-1:0] var_in = '0;
  logic          val_in = 1'b0;
  logic          type_in = 1'b0;
  logic          pop   = 1'b0;
  logic          flush = 1'b0;
  logic          empty_imply, full_imply, val_out_imply, type_out_imply;
  logic [VW-1:0] var_out_imply;
  logic [$clog2(DEPTH):0] count;
  logic          conflict_imply, dup_drop, overflow;

  int nchecks = 0;
  int nerrors = 0;

  imply_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .push(push), .var_in(var_in),
    .val_in(val_in), .type_in(type_in), .pop(pop), .flush(flush),
    .empty_imply(empty_imply), .full_imply(full_imply),
    .var_out_imply(var_out_imply), .val_out_imply(val_out_imply),
    .type_out_imply(type_out_imply), .count(count),
    .conflict_imply(conflict_imply), .dup_drop(dup_drop), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int push, v, val, typ, pop, flush;
    int ecount, eempty, efull, evar, eval, etyp;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(int pu, int v, int vl, int ty, int po, int fl,
                              int ec, int ee, int ef, int ev, int evl, int et);
    vec_t r;
    r.push = pu; r.v = v; r.val = vl; r.typ = ty; r.pop = po; r.flush = fl;
    r.ecount = ec; r.eempty = ee; r.efull = ef; r.evar = ev; r.eval = evl; r.etyp = et;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(int pu, int v, int vl, int ty, int po, int fl);
    push = (pu != 0); var_in = VW'(v); val_in = (vl != 0);
    type_in = (ty != 0); pop = (po != 0); flush = (fl != 0);
  endtask

  // Apply the driven inputs across one rising edge, then return to idle.
  task automatic cyc();
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_push(int v, int vl);
    drive(1, v, vl, 0, 0, 0);
    cyc();
  endtask

  task automatic do_flush();
    drive(0, 0, 0, 0, 0, 1);
    cyc();
  endtask

  initial begin
    vecs[0] = mk(1, 5, 1, 0, 0, 0,  1, 0, 0,  5, 1, 0);
    vecs[1] = mk(1, 7, 0, 1, 0, 0,  2, 0, 0,  5, 1, 0);
    vecs[2] = mk(0, 0, 0, 0, 1, 0,  1, 0, 0,  7, 0, 1);
    vecs[3] = mk(0, 0, 0, 0, 1, 0,  0, 1, 0,  0, 0, 0);
    vecs[4] = mk(0, 0, 0, 0, 1, 0,  0, 1, 0,  0, 0, 0);
    vecs[5] = mk(1, 3, 1, 1, 1, 0,  1, 0, 0,  3, 1, 1);
    vecs[6] = mk(1, 10, 0, 0, 1, 0, 1, 0, 0, 10, 0, 0);
    vecs[7] = mk(1, 11, 1, 0, 0, 1, 0, 1, 0,  0, 0, 0);
    vecs[8] = mk(1, 12, 1, 0, 0, 0, 1, 0, 0, 12, 1, 0);
    vecs[9] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0,  0, 0, 0);

    // Reset state
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty_imply), 1);
    chk("rst_full", int'(full_imply), 0);
    chk("rst_flags", int'({conflict_imply, dup_drop, overflow}), 0);
    @(negedge clock);
    reset = 1'b1;

    // Table-driven basic FIFO behaviour
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      drive(vecs[i].push, vecs[i].v, vecs[i].val, vecs[i].typ, vecs[i].pop, vecs[i].flush);
      cyc();
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].ecount);
      chk($sformatf("v%0d_empty", i), int'(empty_imply), vecs[i].eempty);
      chk($sformatf("v%0d_full", i), int'(full_imply), vecs[i].efull);
      chk($sformatf("v%0d_var", i), int'(var_out_imply), vecs[i].evar);
      chk($sformatf("v%0d_val", i), int'(val_out_imply), vecs[i].eval);
      chk($sformatf("v%0d_type", i), int'(type_out_imply), vecs[i].etyp);
    end

    // Async reset with 3 entries queued, then push right after release
    do_push(1, 0); do_push(2, 1); do_push(3, 0);
    chk("pre_rst_count", int'(count), 3);
    reset = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty_imply), 1);
    chk("async_rst_var", int'(var_out_imply), 0);
    chk("async_rst_flags", int'({conflict_imply, dup_drop, overflow, full_imply}), 0);
    @(negedge clock);
    reset = 1'b1;
    drive(1, 2, 0, 1, 0, 0);
    cyc();
    chk("post_rst_push_count", int'(count), 1);
    chk("post_rst_push_var", int'(var_out_imply), 2);
    do_flush();

    // Overflow: 17 distinct pushes into DEPTH=16
    for (int i = 0; i < 17; i++) do_push(20 + i, i % 2);
    chk("ovf_count", int'(count), 16);
    chk("ovf_full", int'(full_imply), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_head", int'(var_out_imply), 20);
    drive(1, 40, 1, 0, 1, 0);
    cyc();
    chk("full_pushpop_count", int'(count), 16);
    chk("full_pushpop_full", int'(full_imply), 1);
    chk("full_pushpop_head", int'(var_out_imply), 21);
    do_flush();
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_count", int'(count), 0);

    // Pointer wrap: fill 16, pop 10, push 8, drain in order
    for (int i = 0; i < 16; i++) do_push(50 + i, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      cyc();
    end
    chk("wrap_mid_head", int'(var_out_imply), 60);
    for (int i = 0; i < 8; i++) do_push(70 + i, 0);
    chk("wrap_count", int'(count), 14);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("wrap_order%0d", i), int'(var_out_imply), (i < 6) ? 60 + i : 64 + i);
      chk($sformatf("wrap_val%0d", i), int'(val_out_imply), (i < 6) ? 1 : 0);
      drive(0, 0, 0, 0, 1, 0);
      cyc();
    end
    chk("wrap_drained", int'(empty_imply), 1);

    // Duplicate / conflict handling
    drive(1, 4, 1, 0, 0, 0);
    #1;
    chk("dup_first_pulse", int'(dup_drop), 0);
    cyc();
    drive(1, 4, 1, 0, 0, 0);
    #1;
`ifdef IMPLY_QUEUE_DEDUP_EN
    chk("dup_second_pulse", int'(dup_drop), 1);
`else
    chk("dup_second_pulse", int'(dup_drop), 0);
`endif
    cyc();
    chk("dup_pulse_end", int'(dup_drop), 0);
`ifdef IMPLY_QUEUE_DEDUP_EN
    chk("dup_count", int'(count), 1);
`else
    chk("dup_count", int'(count), 2);
`endif
    do_push(4, 0);
`ifdef IMPLY_QUEUE_DEDUP_EN
    chk("conf_flag", int'(conflict_imply), 1);
    chk("conf_count", int'(count), 1);
`else
    chk("conf_flag", int'(conflict_imply), 0);
    chk("conf_count", int'(count), 3);
`endif
    do_flush();
    chk("conf_flush_flag", int'(conflict_imply), 0);
    chk("conf_flush_count", int'(count), 0);

    // Same-cycle pop of head (9,1) with push (9,0)
    do_push(9, 1);
    drive(1, 9, 0, 0, 1, 0);
    cyc();
`ifdef IMPLY_QUEUE_DEDUP_EN
    chk("popconf_count", int'(count), 0);
    chk("popconf_flag", int'(conflict_imply), 1);
`else
    chk("popconf_count", int'(count), 1);
    chk("popconf_flag", int'(conflict_imply), 0);
    chk("popconf_head_val", int'(val_out_imply), 0);
`endif
    do_flush();

    // Pending state clears when its entry is popped
    do_push(6, 1);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    do_push(6, 1);
    chk("repush_count", int'(count), 1);
    chk("repush_head", int'(var_out_imply), 6);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
